adc_stream_framer: RTL and testbench
====================================

Name: adc_stream_framer

Overview:
- Parametrised multi-channel successor to the single-channel ADC UART streamer.
- Paces ADC conversions and accepts raw or filtered sample vectors for NUM_CH channels, selected by UART command.
- Buffers samples with sequence numbers in a FIFO and serialises them as checksummed frames onto the byte-wide UART TX handshake.
- Sits between the ADC controller/FIR filters and the UART tx/rx modules.

Parameters:
NUM_CH, 2, channels per sample vector (1..4)
DATA_W, 12, bits per channel sample (9..16)
CONV_DIV, 12500, clocks per conversion period (10 kHz at 125 MHz)
FIFO_DEPTH, 16, sample vectors buffered (power of 2)
MAX_SAMPLES, 20000, vectors per run; 0 = unlimited

Ports:
clk  in  1  system clock
rst_n  in  1  async reset, active low
rx_data  in  8  received command byte
rx_valid  in  1  1-cycle strobe qualifying rx_data
raw_data  in  NUM_CH*DATA_W  raw ADC vector, ch0 in LSBs
raw_valid  in  1  1-cycle strobe for raw_data
filt_data  in  NUM_CH*DATA_W  filtered vector, same packing
filt_valid  in  1  1-cycle strobe for filt_data
start_conv  out  1  1-cycle conversion request to ADC controller
tx_data  out  8  byte to UART tx
tx_act  out  1  1-cycle send strobe
tx_busy  in  1  UART tx busy
sampling_active  out  1  run in progress
filter_mode  out  1  0 = raw, 1 = filtered
sample_count  out  16  frames fully transmitted this run
drop_count  out  8  vectors dropped on FIFO full, saturates at 255
overflow  out  1  sticky; set on first drop

Behaviour:
- Reset: every output 0, FIFO empty, seq = 0, TX FSM in IDLE.
- Commands, on rx_valid:
  - 0x41 'A': start raw run.
  - 0x46 'F': start filtered run.
  - 0x53 'S': stop.
  - Any other byte: ignored.
- Start (effective the cycle after rx_valid):
  - Set filter_mode.
  - Set sampling_active = 1, conv enable = 1.
  - Flush FIFO; clear seq, pushed count, sample_count, drop_count and overflow.
  - Zero the conv timer.
- Start while active: same restart. A frame already latched into the TX shadow register finishes sending unchanged.
- Stop: conv enable = 0 and no further pushes. Queued vectors still drain. sampling_active falls when FIFO is empty and TX is IDLE.
- Conv timer:
  - Counts 0..CONV_DIV-1 while enabled; start_conv pulses when the count reaches CONV_DIV-1.
  - First pulse comes CONV_DIV cycles after enable.
  - Held at 0 while disabled.
- Push:
  - Trigger: selected-source valid (raw_valid if filter_mode = 0, else filt_valid) while accepting.
  - Entry pushed: {seq[7:0], data}. seq increments on every accepted vector, including dropped ones, so drops appear as gaps.
  - FIFO full: vector dropped; drop_count++ (saturating); overflow = 1.
  - The non-selected source is ignored.
- Run limit: when pushed count reaches MAX_SAMPLES (MAX_SAMPLES != 0), conv enable = 0 and further valids are ignored. The run then ends as for stop.
- Frame layout: 0xA5, seq, then per channel ch0 first: high byte {zero-pad, sample[DATA_W-1:8]}, low byte sample[7:0], then checksum.
  - Checksum = XOR of all bytes after 0xA5.
  - Length = 3 + 2*NUM_CH bytes.
- TX FSM states: IDLE, LOAD, SEND, GUARD, WAITB.
  - IDLE -> LOAD when FIFO not empty.
  - LOAD: pop entry into shadow register, clear checksum.
  - SEND: drive tx_data and pulse tx_act for 1 cycle; fold the byte into the checksum.
  - GUARD: 1 cycle with tx_busy ignored.
  - WAITB: wait for tx_busy = 0, then go to SEND for the next byte.
  - After the checksum byte completes: sample_count++ and back to IDLE.
  - At most one tx_act is outstanding at any time.
- Simultaneous push and pop: both occur; FIFO occupancy is unchanged.
- Simultaneous flush and pop: flush wins; the popped entry is still sent.
- sample_count wraps at 2^16.
- rst_n asserted mid-frame: immediate return to reset state; the partial frame is abandoned.

Decomposition:
- Package adc_stream_pkg holds:
  - tx_state_t enum.
  - SYNC_BYTE = 8'hA5.
  - CMD_RAW = 8'h41, CMD_FILT = 8'h46, CMD_STOP = 8'h53.
  - Frame-length function of NUM_CH.
- One sub-module, sync_fifo:
  - Parameters WIDTH = 8 + NUM_CH*DATA_W and DEPTH.
  - Ports: push, pop, flush, full, empty.
  - Registered read data.

Test Plan:
- Reset, then 'A' with NUM_CH=2, CONV_DIV=100, raw vector {ch1=12'h123, ch0=12'hABC} returned 10 cycles after each start_conv -> start_conv every 100 cycles; frame A5 00 0A BC 01 23 checksum = 0x00^0x0A^0xBC^0x01^0x23; sample_count = 1.
- 'F' with filt_valid and raw_valid both pulsing -> only filt_data appears in frames; filter_mode = 1.
- MAX_SAMPLES=5 -> exactly 5 start_conv pulses and 5 frames with seq 0..4; sampling_active falls after the last checksum byte; sample_count = 5.
- tx_busy held high 2000 cycles, FIFO_DEPTH=4, 7 vectors pushed -> drop_count = 3, overflow = 1; frames carry seq 0..3, and the next accepted vector carries seq 7.
- 'S' mid-frame with 3 vectors queued -> current frame completes, 3 more frames sent, no further start_conv, sampling_active then 0.
- rst_n low during WAITB -> all outputs 0 next cycle; after 'A' the first frame carries seq 0.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC stream framer.
package adc_stream_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND,
        TX_GUARD,
        TX_WAITB
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_RAW   = 8'h41;
    localparam logic [7:0] CMD_FILT  = 8'h46;
    localparam logic [7:0] CMD_STOP  = 8'h53;

    // Sync byte, sequence byte, two bytes per channel, checksum byte.
    function automatic int frame_len(input int num_ch);
        return 3 + 2 * num_ch;
    endfunction

endpackage

// File: rtl/adc_stream_framer_sync_fifo.sv
// Synchronous FIFO with registered read data and a flush that clears occupancy.
// DEPTH must be a power of two, 2 or larger.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && !flush && (!full || do_pop);

    // Storage array; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update and registered read; a pop coinciding with flush still delivers its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pop_data <= '0;
        end else begin
            if (do_pop) begin
                pop_data <= mem[rd_ptr[AW-1:0]];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/adc_stream_framer.sv
// ADC stream framer: paces conversions, buffers raw or filtered sample vectors
// tagged with a sequence number, and sends each as a checksummed UART frame.
//
// TX state | meaning
// IDLE     | waiting for a buffered vector and a free UART
// LOAD     | vector popped into the shadow register, checksum cleared
// SEND     | current byte on tx_data, tx_act pulsed
// GUARD    | one cycle so the UART can raise tx_busy
// WAITB    | waiting for the UART to finish the byte
module adc_stream_framer
    import adc_stream_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 12,
    parameter int CONV_DIV    = 12500,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_SAMPLES = 20000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic [NUM_CH*DATA_W-1:0] raw_data,
    input  logic                     raw_valid,
    input  logic [NUM_CH*DATA_W-1:0] filt_data,
    input  logic                     filt_valid,
    output logic                     start_conv,
    output logic [7:0]               tx_data,
    output logic                     tx_act,
    input  logic                     tx_busy,
    output logic                     sampling_active,
    output logic                     filter_mode,
    output logic [15:0]              sample_count,
    output logic [7:0]               drop_count,
    output logic                     overflow
);

    localparam int VEC_W     = NUM_CH * DATA_W;
    localparam int ENTRY_W   = 8 + VEC_W;
    localparam int FRAME_LEN = frame_len(NUM_CH);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int TMR_W     = (CONV_DIV > 1) ? $clog2(CONV_DIV) : 1;
    localparam int CNT_W     = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES + 1) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CONV_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_SAMPLES > 0) ? MAX_SAMPLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    tx_state_t          state_q;
    tx_state_t          state_d;

    logic               run_en;
    logic [TMR_W-1:0]   conv_tmr;
    logic [7:0]         seq;
    logic [CNT_W-1:0]   pushed_cnt;

    logic               cmd_start;
    logic               cmd_stop;
    logic               sel_valid;
    logic [VEC_W-1:0]   sel_data;
    logic               accept;
    logic               drop;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    logic [ENTRY_W-1:0] shadow;
    logic [IDX_W-1:0]   byte_idx;
    logic [7:0]         csum;
    logic [7:0]         cur_byte;
    logic [15:0]        samp_pad [NUM_CH];
    logic               last_byte;
    logic               frame_done;

    assign cmd_start  = rx_valid && ((rx_data == CMD_RAW) || (rx_data == CMD_FILT));
    assign cmd_stop   = rx_valid && (rx_data == CMD_STOP);

    assign sel_valid  = filter_mode ? filt_valid : raw_valid;
    assign sel_data   = filter_mode ? filt_data  : raw_data;
    // A restart flushes the FIFO this cycle, so any vector arriving with it is discarded.
    assign accept     = run_en && sel_valid && !cmd_start;

    assign fifo_push  = accept;
    assign fifo_wdata = {seq, sel_data};
    // Only fetch a new frame when the UART is free so one tx_act is ever outstanding.
    assign fifo_pop   = (state_q == TX_IDLE) && !fifo_empty && !tx_busy;
    assign drop       = accept && fifo_full && !fifo_pop;

    assign start_conv = run_en && (conv_tmr == TMR_LAST);

    assign last_byte  = (byte_idx == IDX_LAST);
    assign frame_done = (state_q == TX_WAITB) && !tx_busy && last_byte;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (cmd_start),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Run control: command decode, sequence numbering, run limit and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en          <= 1'b0;
            sampling_active <= 1'b0;
            filter_mode     <= 1'b0;
            seq             <= '0;
            pushed_cnt      <= '0;
            sample_count    <= '0;
            drop_count      <= '0;
            overflow        <= 1'b0;
        end else if (cmd_start) begin
            run_en          <= 1'b1;
            sampling_active <= 1'b1;
            filter_mode     <= (rx_data == CMD_FILT);
            seq             <= '0;
            pushed_cnt      <= '0;
            sample_count    <= '0;
            drop_count      <= '0;
            overflow        <= 1'b0;
        end else begin
            if (cmd_stop) begin
                run_en <= 1'b0;
            end
            if (accept) begin
                seq <= seq + 8'd1;
                if (MAX_SAMPLES != 0) begin
                    pushed_cnt <= pushed_cnt + CNT_W'(1);
                    if (pushed_cnt == CNT_LAST) begin
                        run_en <= 1'b0;
                    end
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
            if (frame_done) begin
                sample_count <= sample_count + 16'd1;
            end
            // The run ends once conversions are off and the last queued frame has left.
            if (!run_en && fifo_empty && (state_q == TX_IDLE)) begin
                sampling_active <= 1'b0;
            end
        end
    end

    // Conversion pacing timer: free-runs 0..CONV_DIV-1 while the run is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_tmr <= '0;
        end else if (cmd_start || !run_en || (conv_tmr == TMR_LAST)) begin
            conv_tmr <= '0;
        end else begin
            conv_tmr <= conv_tmr + TMR_W'(1);
        end
    end

    // Byte selection for the frame: sync, seq, per-channel high/low bytes, checksum.
    always_comb begin
        cur_byte = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            samp_pad[c] = 16'(shadow[c*DATA_W +: DATA_W]);
            if (byte_idx == IDX_W'(2 + 2*c)) cur_byte = samp_pad[c][15:8];
            if (byte_idx == IDX_W'(3 + 2*c)) cur_byte = samp_pad[c][7:0];
        end
        if (byte_idx == '0) begin
            cur_byte = SYNC_BYTE;
        end else if (byte_idx == IDX_W'(1)) begin
            cur_byte = shadow[ENTRY_W-1 -: 8];
        end else if (last_byte) begin
            cur_byte = csum;
        end
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TX next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        tx_act  = 1'b0;
        tx_data = 8'h00;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !tx_busy) state_d = TX_LOAD;
            end
            TX_LOAD: begin
                state_d = TX_SEND;
            end
            TX_SEND: begin
                tx_act  = 1'b1;
                tx_data = cur_byte;
                state_d = TX_GUARD;
            end
            TX_GUARD: begin
                state_d = TX_WAITB;
            end
            TX_WAITB: begin
                if (!tx_busy) state_d = last_byte ? TX_IDLE : TX_SEND;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // TX datapath: shadow capture, byte index and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            byte_idx <= '0;
            csum     <= '0;
        end else begin
            case (state_q)
                TX_LOAD: begin
                    shadow   <= fifo_rdata;
                    byte_idx <= '0;
                    csum     <= '0;
                end
                TX_SEND: begin
                    if ((byte_idx != '0) && !last_byte) csum <= csum ^ cur_byte;
                end
                TX_WAITB: begin
                    if (!tx_busy && !last_byte) byte_idx <= byte_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_stream_framer.sv
// Directed bench for adc_stream_framer: command table plus multi-cycle run scenarios.
module tb_adc_stream_framer;

    localparam int NUM_CH   = 2;
    localparam int DATA_W   = 12;
    localparam int UART_CYC = 6;
    localparam int ADC_LAT  = 10;

    localparam logic [23:0] RAW_VEC  = {12'h123, 12'hABC};
    localparam logic [23:0] FILT_VEC = {12'h456, 12'h789};

    typedef struct {
        logic [7:0] cmd;
        logic       exp_fm;
        logic       exp_act;
    } cmd_vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] raw_data;
    logic        raw_valid;
    logic [23:0] filt_data;
    logic        filt_valid;
    logic        start_conv;
    logic [7:0]  tx_data;
    logic        tx_act;
    logic        tx_busy;
    logic        sampling_active;
    logic        filter_mode;
    logic [15:0] sample_count;
    logic [7:0]  drop_count;
    logic        overflow;

    logic        uart_busy;
    logic        hold_busy;
    logic        adc_raw_en;
    logic        adc_filt_en;
    int          busy_cnt;
    int          adc_cnt;
    int          cyc;
    int          conv_count;
    int          last_tx_cyc;
    int          fall_cyc;
    int          n_vec;
    int          n_err;
    logic [7:0]  cap [$];
    int          conv_cyc [$];
    cmd_vec_t    tbl [10];

    assign tx_busy = uart_busy | hold_busy;

    adc_stream_framer #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .CONV_DIV    (100),
        .FIFO_DEPTH  (4),
        .MAX_SAMPLES (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .raw_data        (raw_data),
        .raw_valid       (raw_valid),
        .filt_data       (filt_data),
        .filt_valid      (filt_valid),
        .start_conv      (start_conv),
        .tx_data         (tx_data),
        .tx_act          (tx_act),
        .tx_busy         (tx_busy),
        .sampling_active (sampling_active),
        .filter_mode     (filter_mode),
        .sample_count    (sample_count),
        .drop_count      (drop_count),
        .overflow        (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // UART tx model, frame byte capture and ADC responder, all sampled on the falling edge.
    initial begin
        uart_busy  = 1'b0;
        raw_valid  = 1'b0;
        filt_valid = 1'b0;
        busy_cnt   = 0;
        adc_cnt    = 0;
        conv_count = 0;
        last_tx_cyc = 0;
        forever begin
            @(negedge clk);
            raw_valid  = 1'b0;
            filt_valid = 1'b0;
            if (tx_act) begin
                cap.push_back(tx_data);
                last_tx_cyc = cyc;
                busy_cnt = UART_CYC;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            uart_busy = (busy_cnt != 0);
            if (start_conv) begin
                conv_count++;
                conv_cyc.push_back(cyc);
                adc_cnt = ADC_LAT;
            end else if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    raw_valid  = adc_raw_en;
                    filt_valid = adc_filt_en;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not seen, waited %0d cycles (limit %0d)", name, budget, budget);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while ((cap.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (cap.size() < n) timeout(name, budget);
    endtask

    task automatic wait_conv(input int n, input int budget, input string name);
        int k;
        k = 0;
        while ((conv_count < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (conv_count < n) timeout(name, budget);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (sampling_active && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        fall_cyc = cyc;
        if (sampling_active) timeout(name, budget);
    endtask

    // Builds the expected frame from first principles and compares the captured bytes.
    task automatic check_frame(input string name, input int fidx, input logic [7:0] seq_e,
                               input logic [23:0] vec);
        logic [7:0]  e [7];
        logic [55:0] ef;
        logic [55:0] af;
        logic [11:0] c0;
        logic [11:0] c1;
        c0   = vec[11:0];
        c1   = vec[23:12];
        e[0] = 8'hA5;
        e[1] = seq_e;
        e[2] = {4'h0, c0[11:8]};
        e[3] = c0[7:0];
        e[4] = {4'h0, c1[11:8]};
        e[5] = c1[7:0];
        e[6] = e[1] ^ e[2] ^ e[3] ^ e[4] ^ e[5];
        ef = '0;
        af = '0;
        for (int k = 0; k < 7; k++) begin
            ef = {ef[47:0], e[k]};
            af = {af[47:0], ((fidx*7 + k) < cap.size()) ? cap[fidx*7 + k] : 8'h00};
        end
        check(name, 64'(af), 64'(ef));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_conv"},      64'(start_conv),      64'd0);
        check({tag, "_tx_act"},          64'(tx_act),          64'd0);
        check({tag, "_tx_data"},         64'(tx_data),         64'd0);
        check({tag, "_sampling_active"}, 64'(sampling_active), 64'd0);
        check({tag, "_filter_mode"},     64'(filter_mode),     64'd0);
        check({tag, "_sample_count"},    64'(sample_count),    64'd0);
        check({tag, "_drop_count"},      64'(drop_count),      64'd0);
        check({tag, "_overflow"},        64'(overflow),        64'd0);
    endtask

    initial begin
        tbl[0] = '{8'h53, 1'b0, 1'b0};
        tbl[1] = '{8'h41, 1'b0, 1'b1};
        tbl[2] = '{8'h58, 1'b0, 1'b1};
        tbl[3] = '{8'h46, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h61, 1'b1, 1'b1};
        tbl[6] = '{8'h41, 1'b0, 1'b1};
        tbl[7] = '{8'h53, 1'b0, 1'b0};
        tbl[8] = '{8'h46, 1'b1, 1'b1};
        tbl[9] = '{8'h53, 1'b1, 1'b0};

        n_vec       = 0;
        n_err       = 0;
        fall_cyc    = 0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        raw_data    = RAW_VEC;
        filt_data   = FILT_VEC;
        hold_busy   = 1'b0;
        adc_raw_en  = 1'b0;
        adc_filt_en = 1'b0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Command decode table.
        for (int i = 0; i < 10; i++) begin
            send_cmd(tbl[i].cmd);
            repeat (3) @(negedge clk);
            check($sformatf("cmd%0d_filter_mode", i),     64'(filter_mode),     64'(tbl[i].exp_fm));
            check($sformatf("cmd%0d_sampling_active", i), 64'(sampling_active), 64'(tbl[i].exp_act));
        end

        // Raw run: conversion period, first frame bytes, stop drains the queue.
        cap.delete();
        conv_cyc.delete();
        conv_count = 0;
        adc_raw_en = 1'b1;
        send_cmd(8'h41);
        check("raw_filter_mode", 64'(filter_mode), 64'd0);
        wait_conv(2, 400, "raw_wait_conv");
        check("raw_conv_period", 64'((conv_cyc.size() >= 2) ? conv_cyc[1] - conv_cyc[0] : 0), 64'd100);
        repeat (15) @(negedge clk);
        send_cmd(8'h53);
        wait_idle(600, "raw_wait_idle");
        check("raw_bytes", 64'(cap.size()), 64'd14);
        begin
            logic [55:0] f0;
            f0 = '0;
            for (int k = 0; k < 7; k++) f0 = {f0[47:0], (k < cap.size()) ? cap[k] : 8'h00};
            check("raw_frame0", 64'(f0), 64'hA5000ABC012394);
        end
        check_frame("raw_frame1", 1, 8'd1, RAW_VEC);
        check("raw_sample_count", 64'(sample_count), 64'd2);
        repeat (150) @(negedge clk);
        check("raw_no_conv_after_stop", 64'(conv_count), 64'd2);

        // Filtered run with both sources pulsing: only filtered data may appear.
        cap.delete();
        adc_filt_en = 1'b1;
        send_cmd(8'h46);
        check("filt_filter_mode", 64'(filter_mode), 64'd1);
        check("filt_sample_count_cleared", 64'(sample_count), 64'd0);
        wait_bytes(14, 600, "filt_wait_bytes");
        send_cmd(8'h53);
        wait_idle(600, "filt_wait_idle");
        check("filt_bytes", 64'(cap.size()), 64'd14);
        check_frame("filt_frame0", 0, 8'd0, FILT_VEC);
        check_frame("filt_frame1", 1, 8'd1, FILT_VEC);

        // Run limit of 8 vectors.
        cap.delete();
        adc_filt_en = 1'b0;
        conv_count  = 0;
        send_cmd(8'h41);
        wait_idle(3000, "limit_wait_idle");
        check("limit_conv_count", 64'(conv_count), 64'd8);
        check("limit_bytes", 64'(cap.size()), 64'd56);
        for (int i = 0; i < 8; i++) begin
            check_frame($sformatf("limit_frame%0d", i), i, 8'(i), RAW_VEC);
        end
        check("limit_sample_count", 64'(sample_count), 64'd8);
        check("limit_active_after_last_byte", 64'(fall_cyc > last_tx_cyc), 64'd1);
        check("limit_overflow", 64'(overflow), 64'd0);
        repeat (250) @(negedge clk);
        check("limit_no_more_conv", 64'(conv_count), 64'd8);

        // Overflow: UART held busy while seven vectors arrive into a depth-4 FIFO.
        cap.delete();
        conv_count = 0;
        hold_busy  = 1'b1;
        send_cmd(8'h41);
        wait_conv(7, 1000, "ovf_wait_conv");
        repeat (20) @(negedge clk);
        check("ovf_drop_count", 64'(drop_count), 64'd3);
        check("ovf_overflow", 64'(overflow), 64'd1);
        check("ovf_no_tx_while_busy", 64'(cap.size()), 64'd0);
        hold_busy = 1'b0;
        wait_idle(2000, "ovf_wait_idle");
        check("ovf_bytes", 64'(cap.size()), 64'd35);
        check_frame("ovf_frame0", 0, 8'd0, RAW_VEC);
        check_frame("ovf_frame1", 1, 8'd1, RAW_VEC);
        check_frame("ovf_frame2", 2, 8'd2, RAW_VEC);
        check_frame("ovf_frame3", 3, 8'd3, RAW_VEC);
        check_frame("ovf_frame4", 4, 8'd7, RAW_VEC);
        check("ovf_sample_count", 64'(sample_count), 64'd5);
        check("ovf_drop_count_final", 64'(drop_count), 64'd3);

        // Stop mid-frame with three vectors still queued.
        cap.delete();
        conv_count = 0;
        hold_busy  = 1'b1;
        send_cmd(8'h41);
        wait_conv(4, 600, "stop_wait_conv");
        repeat (15) @(negedge clk);
        check("stop_overflow_cleared", 64'(overflow), 64'd0);
        hold_busy = 1'b0;
        wait_bytes(3, 100, "stop_wait_bytes");
        send_cmd(8'h53);
        wait_idle(1000, "stop_wait_idle");
        check("stop_bytes", 64'(cap.size()), 64'd28);
        for (int i = 0; i < 4; i++) begin
            check_frame($sformatf("stop_frame%0d", i), i, 8'(i), RAW_VEC);
        end
        check("stop_sample_count", 64'(sample_count), 64'd4);
        repeat (200) @(negedge clk);
        check("stop_no_more_conv", 64'(conv_count), 64'd4);
        check("stop_sampling_active", 64'(sampling_active), 64'd0);

        // Reset while waiting on the UART in the middle of a frame.
        cap.delete();
        adc_filt_en = 1'b1;
        send_cmd(8'h46);
        wait_bytes(9, 600, "rstmid_wait_bytes");
        repeat (2) @(negedge clk);
        check("rstmid_pre_sample_count", 64'(sample_count), 64'd1);
        check("rstmid_pre_filter_mode", 64'(filter_mode), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstmid");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cap.delete();
        adc_filt_en = 1'b0;
        send_cmd(8'h41);
        wait_bytes(7, 400, "rstmid_wait_frame");
        check_frame("rstmid_first_frame", 0, 8'd0, RAW_VEC);
        send_cmd(8'h53);
        wait_idle(600, "rstmid_wait_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
